// File: rtl/lms_adapt_ctrl.sv
// Adaptation sequencer for a 16-tap LMS FIR: clear, flush, fast train, slow track,
// with windowed sum-of-|e| energy monitoring for convergence and divergence.
module lms_adapt_ctrl #(
    parameter int              W2        = 32,
    parameter int              L         = 16,
    parameter int              FLUSH_CYC = 19,
    parameter int              WIN_LOG2  = 6,
    parameter int              MU_TRAIN  = 6,
    parameter int              MU_TRACK  = 9,
    parameter longint unsigned CONV_THR  = 64'd4096,
    parameter longint unsigned DIV_THR   = 64'd1 << 36,
    parameter int              CONV_WINS = 4,
    parameter int              MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   sample_valid,
    input  logic [W2-1:0]          e_in,
    output logic                   coef_clear,
    output logic                   adapt_en,
    output logic [3:0]             mu_shift,
    output logic                   converged,
    output logic                   diverged,
    output logic                   fault,
    output logic [2:0]             state,
    output logic [W2+WIN_LOG2-1:0] err_energy
);

    localparam int EW = W2 + WIN_LOG2;
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int CW = $clog2(CONV_WINS + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_WINS - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [EW-1:0] CONV_T     = EW'(CONV_THR);
    localparam logic [EW-1:0] DIV_T      = EW'(DIV_THR);
    localparam logic [3:0]    MU_TR      = 4'(MU_TRAIN);
    localparam logic [3:0]    MU_TK      = 4'(MU_TRACK);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FLUSH = 3'd2,
        ST_TRAIN = 3'd3,
        ST_TRACK = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t                st;
    logic [EW-1:0]         acc;
    logic [WIN_LOG2-1:0]   win_cnt;
    logic [FW-1:0]         flush_cnt;
    logic [CW-1:0]         conv_cnt;
    logic [RW-1:0]         retry;

    logic [W2-1:0]         abs_e;
    logic [EW:0]           sum_wide;
    logic [EW-1:0]         sum;
    logic                  win_end;
    logic                  is_div;
    logic                  is_conv;

    assign state = st;

    // |most-negative| has no positive twin, so it clamps to the largest positive value.
    always_comb begin
        abs_e = e_in;
        if (e_in[W2-1]) begin
            if (e_in == {1'b1, {(W2-1){1'b0}}})
                abs_e = {1'b0, {(W2-1){1'b1}}};
            else
                abs_e = -e_in;
        end
    end

    assign sum_wide = {1'b0, acc} + {{(EW+1-W2){1'b0}}, abs_e};
    assign sum      = sum_wide[EW] ? {EW{1'b1}} : sum_wide[EW-1:0];
    assign win_end  = sample_valid && (win_cnt == {WIN_LOG2{1'b1}});
    assign is_div   = sum > DIV_T;
    assign is_conv  = sum < CONV_T;

    // NOTE: every register here uses <=, so all decisions see the pre-edge values of
    // the counters and state; outputs are set alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_IDLE;
            coef_clear <= 1'b0;
            adapt_en   <= 1'b0;
            mu_shift   <= MU_TR;
            converged  <= 1'b0;
            diverged   <= 1'b0;
            fault      <= 1'b0;
            err_energy <= '0;
            acc        <= '0;
            win_cnt    <= '0;
            flush_cnt  <= '0;
            conv_cnt   <= '0;
            retry      <= '0;
        end else begin
            coef_clear <= 1'b0;
            diverged   <= 1'b0;
            if (stop) begin
                // Freeze, do not erase: coefficients stay as they are.
                st        <= ST_IDLE;
                adapt_en  <= 1'b0;
                converged <= 1'b0;
                fault     <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (start) begin
                            st         <= ST_CLEAR;
                            coef_clear <= 1'b1;
                            mu_shift   <= MU_TR;
                            retry      <= '0;
                        end
                    end
                    ST_CLEAR: begin
                        st        <= ST_FLUSH;
                        acc       <= '0;
                        win_cnt   <= '0;
                        flush_cnt <= '0;
                        conv_cnt  <= '0;
                    end
                    ST_FLUSH: begin
                        if (sample_valid) begin
                            if (flush_cnt == FLUSH_LAST) begin
                                flush_cnt <= '0;
                                st        <= ST_TRAIN;
                                adapt_en  <= 1'b1;
                                mu_shift  <= MU_TR;
                            end else begin
                                flush_cnt <= flush_cnt + 1'b1;
                            end
                        end
                    end
                    ST_TRAIN, ST_TRACK: begin
                        if (sample_valid) begin
                            win_cnt <= win_cnt + 1'b1;
                            if (!win_end) begin
                                acc <= sum;
                            end else begin
                                acc        <= '0;
                                err_energy <= sum;
                                if (is_div) begin
                                    diverged  <= 1'b1;
                                    retry     <= retry + 1'b1;
                                    adapt_en  <= 1'b0;
                                    converged <= 1'b0;
                                    mu_shift  <= MU_TR;
                                    if (retry == RETRY_MAX) begin
                                        st    <= ST_FAULT;
                                        fault <= 1'b1;
                                    end else begin
                                        st         <= ST_CLEAR;
                                        coef_clear <= 1'b1;
                                    end
                                end else if (st == ST_TRAIN) begin
                                    if (is_conv) begin
                                        if (conv_cnt == CONV_LAST) begin
                                            conv_cnt  <= '0;
                                            st        <= ST_TRACK;
                                            mu_shift  <= MU_TK;
                                            converged <= 1'b1;
                                        end else begin
                                            conv_cnt <= conv_cnt + 1'b1;
                                        end
                                    end else begin
                                        conv_cnt <= '0;
                                    end
                                end
                            end
                        end
                    end
                    ST_FAULT: begin
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

    // L only documents the filter the flush length was derived from.
    logic unused_l;
    assign unused_l = ^L;

endmodule

// File: doc/lms_adapt_ctrl.md
Name: lms_adapt_ctrl

Overview:
- Sequences a 16-tap LMS adaptive FIR: clears coefficients, waits for the delay line to fill, runs a fast-training phase, then a slow-tracking phase.
- Watches the filter error e_out as windowed sum-of-|e| energy to detect convergence and divergence.
- Drives the filter's coefficient-clear, adapt-enable and step-size (mu right-shift) inputs.
- Sits beside the adaptive FIR and is driven by the system sequencer.

Parameters:
W2, 32, error sample width (signed)
L, 16, filter taps
FLUSH_CYC, 19, samples to wait after clear (L + 3-stage input delay)
WIN_LOG2, 6, energy window = 2^WIN_LOG2 samples (64)
MU_TRAIN, 6, mu shift during TRAIN
MU_TRACK, 9, mu shift during TRACK
CONV_THR, 4096, window energy below this counts as a converged window
DIV_THR, 2^36, window energy above this means divergence
CONV_WINS, 4, consecutive converged windows needed to enter TRACK
MAX_RETRY, 3, divergence restarts allowed before FAULT

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  level/pulse; begins adaptation from IDLE
stop  in  1  abort to IDLE from any state
sample_valid  in  1  one pulse per filter output sample
e_in  in  W2  signed filter error (e_out)
coef_clear  out  1  one-cycle pulse; filter zeroes coefficients
adapt_en  out  1  coefficient update enable
mu_shift  out  4  step-size right-shift applied to e*x
converged  out  1  high while in TRACK
diverged  out  1  one-cycle pulse on each divergence detect
fault  out  1  high in FAULT
state  out  3  IDLE=0, CLEAR=1, FLUSH=2, TRAIN=3, TRACK=4, FAULT=5
err_energy  out  W2+WIN_LOG2  last completed window energy (unsigned)

Behaviour:
- All outputs are registered; state change is visible on outputs the cycle after the deciding edge.
- Reset values: state=IDLE, all flags 0, mu_shift=MU_TRAIN, err_energy=0, retry count 0, all counters and accumulator 0.
- IDLE: adapt_en=0. start=1 and stop=0 -> CLEAR; retry count cleared.
- CLEAR: coef_clear=1 for exactly this one cycle; accumulator and window counters cleared; -> FLUSH.
- FLUSH: adapt_en=0. Counts sample_valid pulses. -> TRAIN on the clock of the FLUSH_CYC-th pulse.
- TRAIN: adapt_en=1, mu_shift=MU_TRAIN.
- TRACK: adapt_en=1, mu_shift=MU_TRACK, converged=1.
- Energy accumulation (TRAIN and TRACK only, on sample_valid): acc += |e_in|.
  - |most-negative| saturates to 2^(W2-1)-1.
  - acc saturates at all-ones; it never wraps.
- Window end (the 2^WIN_LOG2-th sample, including that sample):
  - err_energy <= final sum.
  - acc restarts at 0 on the next sample.
- Checks at window end, applied in this priority order:
  1. Energy > DIV_THR: diverged pulse, retry+1. If retry was already MAX_RETRY -> FAULT, otherwise -> CLEAR.
  2. Else in TRAIN, energy < CONV_THR: conv count +1. Reaching CONV_WINS -> TRACK.
  3. Else in TRAIN, any other energy: conv count resets to 0.
  4. TRACK never returns to TRAIN except through divergence.
- Energy exactly equal to a threshold is neither converged nor divergent.
- FAULT: adapt_en=0, fault=1. Leaves only on stop or reset.
- stop=1 in any state -> IDLE next cycle, adapt_en=0. No coef_clear; coefficients are frozen, not erased.
- stop has priority over start and over a simultaneous window decision.
- start is ignored outside IDLE.
- sample_valid=0: counters and accumulator hold.
- Reset mid-operation: immediate return to reset values. coef_clear is not asserted by reset itself.

Test Plan:
1. Reset, start pulse, 19 sample_valid with e_in=0 -> coef_clear high one cycle; state 1,2,...; TRAIN entered after the 19th pulse; adapt_en=1, mu_shift=6.
2. In TRAIN feed 4x64 samples of e_in=+/-50 (energy 3200 < 4096) -> TRACK after the 256th sample; mu_shift=9, converged=1, err_energy=3200.
3. TRAIN with e_in=64 for 64 samples (energy exactly 4096), then 4 windows of e_in=10 -> conv count reset by the first window; TRACK only after the 5th window.
4. In TRACK feed e_in=2^31-1 for 64 samples (energy 137438953408 > 2^36) -> diverged pulse, CLEAR with coef_clear, FLUSH; converged=0.
5. Force 4 divergent windows with flushes between them -> after the 4th, state=FAULT, fault=1, adapt_en=0; start ignored; stop -> IDLE.
6. e_in=-2^31 for 64 samples -> saturated |e| sums to 137438953408 with no wrap. stop asserted with start in the same cycle mid-TRAIN -> IDLE, no coef_clear.
